// File: rtl/vga_rect_address_scanner.sv
// Walks a rectangle in raster order and emits one pixel beat (x, y, colour, y*H_RES+x) per handshake.
// Define VGA_SCAN_CLIP_EN to clip the rectangle to the visible H_RES x V_RES area.
module vga_rect_address_scanner #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                busy,
    output logic                done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic [ADDR_W-1:0]   mem_address
);

`ifdef VGA_SCAN_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [X_W:0]      H_RES_X = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]      V_RES_Y = (Y_W+1)'(V_RES);
    localparam logic [X_W:0]      ONE_X   = (X_W+1)'(1);
    localparam logic [Y_W:0]      ONE_Y   = (Y_W+1)'(1);
    localparam logic [ADDR_W-1:0] H_STEP  = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [X_W:0]        ew_q, ew_d;
    logic [Y_W:0]        eh_q, eh_d;
    logic [X_W:0]        col_q, col_d;
    logic [Y_W:0]        row_q, row_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    // Clipping arithmetic is one bit wider than the coordinates so it never wraps.
    logic [X_W:0]        x0_ext, x_room, ew_clip;
    logic [Y_W:0]        y0_ext, y_room, eh_clip;
    logic [ADDR_W-1:0]   row_base_load;

    always_comb begin
        x0_ext        = {1'b0, x0_q};
        y0_ext        = {1'b0, y0_q};
        x_room        = (x0_ext >= H_RES_X) ? '0 : (H_RES_X - x0_ext);
        y_room        = (y0_ext >= V_RES_Y) ? '0 : (V_RES_Y - y0_ext);
        ew_clip       = (CLIP_EN && (x_room < ew_q)) ? x_room : ew_q;
        eh_clip       = (CLIP_EN && (y_room < eh_q)) ? y_room : eh_q;
        row_base_load = ADDR_W'(y0_q) * H_STEP;
    end

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        ew_d       = ew_q;
        eh_d       = eh_q;
        col_d      = col_q;
        row_d      = row_q;
        colour_d   = colour_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    ew_d     = {1'b0, w};
                    eh_d     = {1'b0, h};
                    colour_d = colour_in;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                ew_d = ew_clip;
                eh_d = eh_clip;
                if ((ew_clip == '0) || (eh_clip == '0)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    col_d      = '0;
                    row_d      = '0;
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_base_d = row_base_load;
                    addr_d     = row_base_load + ADDR_W'(x0_q);
                    valid_d    = 1'b1;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (valid_q && out_ready) begin
                    if (col_q == ew_q - ONE_X) begin
                        if (row_q == eh_q - ONE_Y) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            // Next row: the base advances by one line, no multiply needed.
                            col_d      = '0;
                            row_d      = row_q + ONE_Y;
                            x_d        = x0_q;
                            y_d        = y_q + Y_W'(1);
                            row_base_d = row_base_q + H_STEP;
                            addr_d     = row_base_q + H_STEP + ADDR_W'(x0_q);
                        end
                    end else begin
                        col_d  = col_q + ONE_X;
                        x_d    = x_q + X_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            ew_q       <= '0;
            eh_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            colour_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            ew_q       <= ew_d;
            eh_q       <= eh_d;
            col_q      <= col_d;
            row_q      <= row_d;
            colour_q   <= colour_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign out_valid   = valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign mem_address = addr_q;

endmodule

// File: tb/tb_vga_rect_address_scanner.sv
// Scoreboard bench: expected beats are queued from a reference model when a rectangle is requested
// and popped as the scanner hands beats over; a second instance covers a 320x240 frame.
module tb_vga_rect_address_scanner;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0_i = '0, w_i = '0;
    logic [6:0] y0_i = '0, h_i = '0;
    logic [2:0] colour_i = '0;
    logic       out_ready = 1'b1;
    logic       busy, done, out_valid;
    logic [7:0] x_o;
    logic [6:0] y_o;
    logic [2:0] colour_o;
    logic [14:0] addr_o;

    logic       start_b = 1'b0;
    logic [8:0] x0_b = '0, w_b = '0;
    logic [7:0] y0_b = '0, h_b = '0;
    logic [2:0] colour_b = '0;
    logic       ready_b = 1'b1;
    logic       busy_b, done_b, valid_b;
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic [2:0] colour_ob;
    logic [16:0] addr_b;

    vga_rect_address_scanner dut (
        .clock(clock), .resetn(resetn), .start(start),
        .x0(x0_i), .y0(y0_i), .w(w_i), .h(h_i), .colour_in(colour_i),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .x(x_o), .y(y_o), .colour(colour_o), .mem_address(addr_o)
    );

    vga_rect_address_scanner #(
        .H_RES(320), .V_RES(240), .X_W(9), .Y_W(8), .ADDR_W(17), .COLOUR_W(3)
    ) dut_hd (
        .clock(clock), .resetn(resetn), .start(start_b),
        .x0(x0_b), .y0(y0_b), .w(w_b), .h(h_b), .colour_in(colour_b),
        .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(ready_b),
        .x(x_b), .y(y_b), .colour(colour_ob), .mem_address(addr_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
        int a;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int beats_seen = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit hold_v = 1'b0;
    logic [32:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor: counts busy/done cycles, pops the scoreboard on each handshake, checks stall stability.
    always @(negedge clock) begin
        if (resetn) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (hold_v && out_valid)
                chk("stall_hold", {x_o, y_o, colour_o, addr_o}, held);
            hold_v = out_valid && !out_ready;
            held   = {x_o, y_o, colour_o, addr_o};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_x", x_o, e.x);
                    chk("beat_y", y_o, e.y);
                    chk("beat_colour", colour_o, e.c);
                    chk("beat_addr", addr_o, e.a);
                    $display("beat %0d: x=%0d y=%0d colour=%0d addr=%0d", beats_seen, x_o, y_o, colour_o, addr_o);
                end
                beats_seen++;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    function automatic int push_rect(int x0, int y0, int w, int h, int c);
        int ew = w;
        int eh = h;
        beat_t b;
`ifdef VGA_SCAN_CLIP_EN
        ew = (x0 >= 160) ? 0 : ((w < 160 - x0) ? w : 160 - x0);
        eh = (y0 >= 120) ? 0 : ((h < 120 - y0) ? h : 120 - y0);
`endif
        for (int r = 0; r < eh; r++) begin
            for (int k = 0; k < ew; k++) begin
                b.x = (x0 + k) % 256;
                b.y = (y0 + r) % 128;
                b.c = c;
                b.a = ((y0 + r) * 160 + x0 + k) % 32768;
                exp_q.push_back(b);
            end
        end
        return ew * eh;
    endfunction

    // stall: hold ready low 3 cycles on beats 2 and 5; ign: pulse start while busy at beat 4.
    task automatic run_rect(input int x0, input int y0, input int w, input int h, input int c,
                            input bit stall, input bit ign);
        int n, lat, exp_lat, start_cyc, stall_left;
        bit s1, s4, ig_done;
        n = push_rect(x0, y0, w, h, c);
        exp_lat = n + 1 + (stall ? 6 : 0);
        lat = -1;
        stall_left = 0;
        s1 = 1'b0;
        s4 = 1'b0;
        ig_done = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        beats_seen = 0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        x0_i = x0[7:0]; y0_i = y0[6:0]; w_i = w[7:0]; h_i = h[6:0]; colour_i = c[2:0];
        start = 1'b1;
        start_cyc = cyc + 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = cyc - start_cyc;
                break;
            end
            if (ign && beats_seen == 3 && !ig_done) begin
                start = 1'b1;
                x0_i = 8'd0; y0_i = 7'd0; w_i = 8'd1; h_i = 7'd1; colour_i = 3'd7;
                ig_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (stall && beats_seen == 1 && !s1) begin
                s1 = 1'b1; out_ready = 1'b0; stall_left = 2;
            end else if (stall && beats_seen == 4 && !s4) begin
                s4 = 1'b1; out_ready = 1'b0; stall_left = 2;
            end else begin
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_latency", lat, exp_lat);
        repeat (3) @(posedge clock);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("busy_cycles", busy_cnt, exp_lat);
        chk("busy_after", busy, 0);
        chk("beats_left", exp_q.size(), 0);
        $display("rect x0=%0d y0=%0d w=%0d h=%0d: beats=%0d latency=%0d", x0, y0, w, h, n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        bit reached;
        int hd_exp[4];

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outs", {busy, done, out_valid, x_o, y_o, colour_o, addr_o}, 0);
        chk("reset_outs_hd", {busy_b, done_b, valid_b, x_b, y_b, colour_ob, addr_b}, 0);
        resetn = 1'b1;

        run_rect(10, 5, 3, 2, 5, 1'b0, 1'b0);     // 810..812, 970..972
        run_rect(10, 5, 3, 2, 6, 1'b1, 1'b0);     // same with stalls
        run_rect(158, 119, 5, 3, 2, 1'b0, 1'b0);  // clipped corner
        run_rect(170, 10, 2, 1, 3, 1'b0, 1'b0);   // fully off-screen when clipped
        run_rect(20, 20, 0, 4, 1, 1'b0, 1'b0);    // empty
        run_rect(30, 40, 3, 2, 4, 1'b0, 1'b1);    // start while busy ignored

        // Reset in the middle of a scan, then restart.
        void'(push_rect(10, 5, 3, 2, 7));
        beats_seen = 0;
        reached = 1'b0;
        @(posedge clock); #1;
        x0_i = 8'd10; y0_i = 7'd5; w_i = 8'd3; h_i = 7'd2; colour_i = 3'd7;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (beats_seen >= 2) begin
                reached = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("mid_scan_reached", reached, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_reset_outs", {busy, done, out_valid, x_o, y_o, colour_o, addr_o}, 0);
        exp_q.delete();
        @(posedge clock); #1;
        resetn = 1'b1;
        run_rect(10, 5, 3, 2, 7, 1'b0, 1'b0);

        // 320x240 instance: bottom-right 2x2 block ending at (319,239) -> 76799.
        for (int k = 0; k < 4; k++) hd_exp[k] = (238 + k / 2) * 320 + 318 + k % 2;
        @(posedge clock); #1;
        x0_b = 9'd318; y0_b = 8'd238; w_b = 9'd2; h_b = 8'd2; colour_b = 3'd5;
        start_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            @(negedge clock);
            if (valid_b) begin
                chk("hd_addr", addr_b, hd_exp[got]);
                $display("hd beat %0d: x=%0d y=%0d addr=%0d", got, x_b, y_b, addr_b);
                got++;
            end
        end
        chk("hd_beats", got, 4);
        chk("hd_last_xy", {x_b, y_b}, {9'd319, 8'd239});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
